// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// using two chained half_adder cells as the per-bit full adder.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [WIDTH-1:0]   sh_a_r;
  logic [WIDTH-1:0]   sh_b_r;
  logic [WIDTH-2:0]   sh_s_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;

  logic               ab_sum_s;
  logic               ab_carry_s;
  logic               bit_s;
  logic               bit_carry_s;
  logic               carry_nx_s;
  logic               last_s;
  logic               load_s;
  logic [WIDTH-1:0]   sh_s_nx_s;

  half_adder u_ha_ab (
    .x (sh_a_r[0]),
    .y (sh_b_r[0]),
    .s (ab_sum_s),
    .c (ab_carry_s)
  );

  half_adder u_ha_carry (
    .x (ab_sum_s),
    .y (carry_r),
    .s (bit_s),
    .c (bit_carry_s)
  );

  assign carry_nx_s = ab_carry_s | bit_carry_s;
  assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));
  assign load_s     = start && ((state_r == IDLE) || (state_r == DONE));
  // Full result word once the current bit lands; the shift register keeps only the upper WIDTH-1 bits.
  assign sh_s_nx_s  = {bit_s, sh_s_r};

  // Next-state decode for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath shift registers and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sh_a_r  <= {WIDTH{1'b0}};
      sh_b_r  <= {WIDTH{1'b0}};
      sh_s_r  <= {(WIDTH-1){1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SHIFT);
      done_r  <= (state_nx_s == DONE);
      if (load_s) begin
        sh_a_r  <= a;
        sh_b_r  <= b;
        sh_s_r  <= {(WIDTH-1){1'b0}};
        carry_r <= cin;
        cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == SHIFT) begin
        sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
        sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
        sh_s_r  <= sh_s_nx_s[WIDTH-1:1];
        carry_r <= carry_nx_s;
        cnt_r   <= cnt_r + CNT_W'(1);
        if (last_s) begin
          sum_r  <= sh_s_nx_s;
          cout_r <= carry_nx_s;
        end else begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
      end else begin
        sh_a_r  <= sh_a_r;
        sh_b_r  <= sh_b_r;
        sh_s_r  <= sh_s_r;
        carry_r <= carry_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule
